namuru_evt_capture: RTL

Event capture stage in the system clock domain, directly downstream of the Namuru four-stage level synchroniser. The correlator domain signals each event (accumulation/TIC) by toggling a level; this block receives that synchronised level, detects each toggle, timestamps it against a free-running system-clock counter and holds the event pending until software acknowledges it. Events that arrive while one is still pending are reported as overruns. It also raises a one-cycle interrupt strobe.

---
 rtl/namuru_evt_pkg.sv | 13 +
 rtl/namuru_toggle_edge.sv | 27 ++
 rtl/namuru_evt_capture.sv | 69 ++++++
 3 files changed

// File: rtl/namuru_evt_pkg.sv
// Shared widths and helpers for the Namuru event capture path.
package namuru_evt_pkg;

    localparam int TS_W_DEF   = 32;
    localparam int CNT_W_DEF  = 16;
    localparam int LOST_W_DEF = 8;

    // Increment that sticks at maxv instead of rolling over.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
        return (v >= maxv) ? maxv : v + 32'd1;
    endfunction

endpackage

// File: rtl/namuru_toggle_edge.sv
// Purpose: turn a synchronised toggle level into a one-cycle event flag.
// Latency: evt is combinational from sync_i against last cycle's level.
// Backpressure: none; one toggle per clock at most is assumed.
module namuru_toggle_edge (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic sync_i,
    output logic evt
);

    logic prev;
    logic armed;

    // The first cycle out of reset only samples the level, so a line resting high is not an edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= sync_i;
            armed <= 1'b1;
        end
    end

    assign evt = armed & (sync_i ^ prev);

endmodule

// File: rtl/namuru_evt_capture.sv
// Purpose: timestamp correlator toggle events and hold them pending until acknowledged.
// Latency: one cycle from a toggle on sync_i to pending/irq/ts_latched/evt_count.
// Backpressure: none; events arriving while pending are counted as lost and flag overrun.
module namuru_evt_capture
    import namuru_evt_pkg::*;
#(
    parameter int TS_W   = TS_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int LOST_W = LOST_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sync_i,
    input  logic              enable,
    input  logic              ack,
    output logic              pending,
    output logic              irq,
    output logic              overrun,
    output logic [TS_W-1:0]   ts_latched,
    output logic [CNT_W-1:0]  evt_count,
    output logic [LOST_W-1:0] lost_count
);

    logic [TS_W-1:0] ts_cnt;
    logic            evt;
    logic            accept;
    logic            drop;

    namuru_toggle_edge u_edge (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .sync_i  (sync_i),
        .evt     (evt)
    );

    // An ack in the same cycle frees the slot, so the new event takes it.
    assign accept = evt & enable & (~pending | ack);
    assign drop   = evt & enable & pending & ~ack;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ts_cnt     <= '0;
            ts_latched <= '0;
            evt_count  <= '0;
            lost_count <= '0;
            pending    <= 1'b0;
            irq        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            irq    <= accept;
            if (accept | drop)
                evt_count <= evt_count + CNT_W'(1);
            if (accept) begin
                ts_latched <= ts_cnt;
                pending    <= 1'b1;
                if (ack)
                    overrun <= 1'b0;
            end else if (drop) begin
                overrun    <= 1'b1;
                lost_count <= LOST_W'(sat_inc(32'(lost_count), 32'({LOST_W{1'b1}})));
            end else if (ack) begin
                pending <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule
